mem_bus_arbiter: RTL and testbench

//   Shares the single external memory bus (16-bit address, 8-bit bidirectional data) between the
//   CPU6 microengine and a DMA channel. Sequences each granted access through address/wait/

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_bus_wait_counter.sv | 25 ++
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the CPU6 memory bus arbiter: bus widths, FSM states,
// owner codes and the request bundle latched on grant.
package mem_bus_arbiter_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int WCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/mem_bus_arbiter_bus_wait_counter.sv
// Loadable 4-bit down-counter that times the ACCESS phase. term is high when
// the count has reached zero, i.e. in the last cycle of the access.
module bus_wait_counter
  import mem_bus_arbiter_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              enable,
  input  logic [WCNT_W-1:0] load_val,
  output logic              term
);

  logic [WCNT_W-1:0] count;

  // Load has priority; counting stops at zero so term stays stable
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                      count <= '0;
    else if (load)                  count <= load_val;
    else if (enable && count != '0) count <= count - 1'b1;
  end

  assign term = (count == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the external memory bus between the CPU6 microengine and the DMA
// channel. Each grant runs IDLE -> ACCESS (WAIT_STATES+1 cycles) -> DONE
// (turnaround + ack). DMA wins ties until it has taken DMA_MAX_BURST grants
// in a row against a waiting CPU. Every output comes straight from a flop.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int WAIT_STATES   = 2,
  parameter int DMA_MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic              mem_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        bus_owner
);

  localparam logic [WCNT_W-1:0] WAIT_LOAD = WCNT_W'(WAIT_STATES);
  localparam logic [3:0]        BURST_MAX = 4'(DMA_MAX_BURST);

  state_t     state, state_nxt;
  owner_t     owner, owner_nxt;
  logic       grant_cpu, grant_dma, grant_any;
  logic [3:0] burst_cnt;
  logic       wc_term;
  logic       cs_nxt, we_nxt, oe_nxt, cpu_ack_nxt, dma_ack_nxt;
  bus_req_t   cpu_bus, dma_bus, sel_bus;

  assign cpu_bus   = {cpu_we, cpu_addr, cpu_wdata};
  assign dma_bus   = {dma_we, dma_addr, dma_wdata};
  assign sel_bus   = grant_cpu ? cpu_bus : dma_bus;
  assign grant_any = grant_cpu | grant_dma;
  assign bus_owner = owner;

  // Grant select: only in IDLE; DMA wins ties until its burst budget is spent
  always_comb begin
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state == ST_IDLE) begin
      if (cpu_req && dma_req) begin
        if (burst_cnt == BURST_MAX) grant_cpu = 1'b1;
        else                        grant_dma = 1'b1;
      end else if (cpu_req) begin
        grant_cpu = 1'b1;
      end else if (dma_req) begin
        grant_dma = 1'b1;
      end
    end
  end

  bus_wait_counter u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (grant_any),
    .enable   (state == ST_ACCESS),
    .load_val (WAIT_LOAD),
    .term     (wc_term)
  );

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // FSM next state: DONE is the unconditional turnaround cycle
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:   if (grant_any) state_nxt = ST_ACCESS;
      ST_ACCESS: if (wc_term)   state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: next values for the registered bus strobes, owner and acks
  always_comb begin
    cs_nxt      = mem_cs;
    we_nxt      = mem_we;
    oe_nxt      = mem_oe;
    owner_nxt   = owner;
    cpu_ack_nxt = 1'b0;
    dma_ack_nxt = 1'b0;
    unique case (state)
      ST_IDLE: begin
        cs_nxt    = grant_any;
        we_nxt    = grant_any & sel_bus.we;
        oe_nxt    = grant_any & sel_bus.we;
        owner_nxt = grant_cpu ? OWN_CPU : (grant_dma ? OWN_DMA : OWN_NONE);
      end
      ST_ACCESS: begin
        if (wc_term) begin
          cs_nxt      = 1'b0;
          we_nxt      = 1'b0;
          oe_nxt      = 1'b0;
          cpu_ack_nxt = (owner == OWN_CPU);
          dma_ack_nxt = (owner == OWN_DMA);
        end
      end
      ST_DONE: begin
        cs_nxt    = 1'b0;
        we_nxt    = 1'b0;
        oe_nxt    = 1'b0;
        owner_nxt = OWN_NONE;
      end
      default: begin
        cs_nxt    = 1'b0;
        we_nxt    = 1'b0;
        oe_nxt    = 1'b0;
        owner_nxt = OWN_NONE;
      end
    endcase
  end

  // Output registers; address/data latch only on grant and hold afterwards
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_oe    <= 1'b0;
      owner     <= OWN_NONE;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_cs  <= cs_nxt;
      mem_we  <= we_nxt;
      mem_oe  <= oe_nxt;
      owner   <= owner_nxt;
      cpu_ack <= cpu_ack_nxt;
      dma_ack <= dma_ack_nxt;
      if (grant_any) begin
        mem_addr  <= sel_bus.addr;
        mem_wdata <= sel_bus.wdata;
      end
    end
  end

  // Read data capture on the last ACCESS edge, into the owner's register only
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else if (state == ST_ACCESS && wc_term && !mem_we) begin
      if (owner == OWN_CPU) cpu_rdata <= mem_rdata;
      if (owner == OWN_DMA) dma_rdata <= mem_rdata;
    end
  end

  // DMA burst budget: counts DMA grants taken while the CPU was waiting
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          burst_cnt <= '0;
    else if (grant_cpu) burst_cnt <= '0;
    else if (grant_dma) begin
      if (!cpu_req)                    burst_cnt <= '0;
      else if (burst_cnt != BURST_MAX) burst_cnt <= burst_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios on a WAIT_STATES=2 instance,
// a WAIT_STATES=0 instance, and a randomized run against a cycle-count model.
module tb_mem_bus_arbiter;

  localparam int W    = 2;
  localparam int MAXB = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // main instance
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [15:0] cpu_addr = 0, dma_addr = 0;
  logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
  logic        cpu_ack, dma_ack, mem_cs, mem_we, mem_oe;
  logic [7:0]  cpu_rdata, dma_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;
  logic [1:0]  bus_owner;
  logic        force_en = 1'b1;
  logic [7:0]  force_val = 8'h00;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] + a[15:8] + 8'h3B;
  endfunction

  assign mem_rdata = force_en ? force_val : mem_fn(mem_addr);

  mem_bus_arbiter #(.WAIT_STATES(W), .DMA_MAX_BURST(MAXB)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .bus_owner(bus_owner)
  );

  // zero-wait-state instance
  logic        z_cpu_req = 0, z_cpu_we = 0, z_dma_req = 0, z_dma_we = 0;
  logic [15:0] z_cpu_addr = 0, z_dma_addr = 0;
  logic [7:0]  z_cpu_wdata = 0, z_dma_wdata = 0, z_mem_rdata = 0;
  logic        z_cpu_ack, z_dma_ack, z_mem_cs, z_mem_we, z_mem_oe;
  logic [7:0]  z_cpu_rdata, z_dma_rdata, z_mem_wdata;
  logic [15:0] z_mem_addr;
  logic [1:0]  z_bus_owner;

  mem_bus_arbiter #(.WAIT_STATES(0), .DMA_MAX_BURST(MAXB)) dut0 (
    .clock(clock), .reset(reset),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_ack(z_cpu_ack), .cpu_rdata(z_cpu_rdata),
    .dma_req(z_dma_req), .dma_we(z_dma_we), .dma_addr(z_dma_addr), .dma_wdata(z_dma_wdata),
    .dma_ack(z_dma_ack), .dma_rdata(z_dma_rdata),
    .mem_cs(z_mem_cs), .mem_we(z_mem_we), .mem_oe(z_mem_oe), .mem_addr(z_mem_addr),
    .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata), .bus_owner(z_bus_owner)
  );

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cpu_ack, dma_ack, mem_cs, mem_we, mem_oe} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {cpu_ack, dma_ack, mem_cs, mem_we, mem_oe});
    end
    checks++;
    if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata, bus_owner} !== 42'b0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, mem_wdata, cpu_rdata, dma_rdata, bus_owner});
    end
    checks++;
    if ({z_cpu_ack, z_dma_ack, z_mem_cs, z_mem_we, z_mem_oe, z_mem_addr, z_mem_wdata,
         z_cpu_rdata, z_dma_rdata, z_bus_owner} !== 47'b0) begin
      errors++; $display("FAIL reset_ws0 got nonzero outputs exp 0");
    end
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b0;
  endtask

  // CPU read: req raised after edge k, ack after edge k+W+2
  task automatic test_cpu_read();
    int cs_n = 0, ack_n = 0, ack_e = 0, dseen = 0;
    logic [1:0] own1 = 0;
    @(negedge clock);
    force_en = 1; force_val = 8'hA5; cpu_we = 0; cpu_addr = 16'h0100; cpu_req = 1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clock); #1;
      if (e == 1) own1 = bus_owner;
      if (mem_cs) cs_n++;
      if (dma_ack) dseen++;
      if (cpu_ack) begin ack_n++; ack_e = e; cpu_req = 0; end
    end
    checks++; if (cs_n !== 3) begin errors++; $display("FAIL rd_cs_cycles got %0d exp 3", cs_n); end
    checks++; if (ack_n !== 1) begin errors++; $display("FAIL rd_ack_count got %0d exp 1", ack_n); end
    checks++; if (ack_e !== 4) begin errors++; $display("FAIL rd_ack_edge got %0d exp 4", ack_e); end
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL rd_data got %h exp a5", cpu_rdata); end
    checks++; if (dseen !== 0) begin errors++; $display("FAIL rd_dma_ack got %0d exp 0", dseen); end
    checks++; if (own1 !== 2'd1) begin errors++; $display("FAIL rd_owner got %0d exp 1", own1); end
  endtask

  task automatic test_cpu_write();
    int cs_n = 0, bad = 0, ack_n = 0;
    @(negedge clock);
    force_val = 8'h77; cpu_we = 1; cpu_addr = 16'h1234; cpu_wdata = 8'h3C; cpu_req = 1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clock); #1;
      if (mem_cs) begin
        cs_n++;
        if (!mem_we || !mem_oe || mem_addr !== 16'h1234 || mem_wdata !== 8'h3C) bad++;
      end else if (mem_we || mem_oe) bad++;
      if (cpu_ack) begin ack_n++; cpu_req = 0; end
    end
    cpu_we = 0;
    checks++; if (bad !== 0) begin errors++; $display("FAIL wr_strobes bad_cycles %0d exp 0", bad); end
    checks++; if (cs_n !== 3) begin errors++; $display("FAIL wr_cs_cycles got %0d exp 3", cs_n); end
    checks++; if (ack_n !== 1) begin errors++; $display("FAIL wr_ack_count got %0d exp 1", ack_n); end
    checks++; if (cpu_rdata !== 8'hA5) begin errors++; $display("FAIL wr_rdata_kept got %h exp a5", cpu_rdata); end
  endtask

  // both requests rise together: DMA first, DONE + IDLE, then CPU
  task automatic test_simultaneous();
    int d_e = 0, c_e = 0;
    logic [1:0] own [1:14];
    @(negedge clock);
    force_val = 8'h11; cpu_we = 0; dma_we = 0; cpu_addr = 16'h0010; dma_addr = 16'h0020;
    cpu_req = 1; dma_req = 1;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clock); #1;
      own[e] = bus_owner;
      if (dma_ack) begin d_e = e; dma_req = 0; end
      if (cpu_ack) begin c_e = e; cpu_req = 0; end
    end
    checks++; if (d_e !== 4) begin errors++; $display("FAIL sim_dma_ack_edge got %0d exp 4", d_e); end
    checks++; if (c_e !== 9) begin errors++; $display("FAIL sim_cpu_ack_edge got %0d exp 9", c_e); end
    checks++;
    if ({own[4], own[5], own[6], own[10]} !== {2'd2, 2'd0, 2'd1, 2'd0}) begin
      errors++; $display("FAIL sim_owner_seq got %0d %0d %0d %0d exp 2 0 1 0", own[4], own[5], own[6], own[10]);
    end
  endtask

  // DMA held high: four DMA grants, then the waiting CPU, then DMA again
  task automatic test_dma_burst();
    logic [9:0] seq = '0;
    int n = 0, both = 0;
    bit rearm = 0;
    @(negedge clock);
    cpu_req = 1; dma_req = 1;
    for (int e = 1; e <= 80; e++) begin
      @(posedge clock); #1;
      if (rearm) begin cpu_req = 1; rearm = 0; end
      if (cpu_ack && dma_ack) both++;
      if (n < 10 && (cpu_ack || dma_ack)) begin
        seq[n] = cpu_ack;
        n++;
        if (cpu_ack) begin cpu_req = 0; rearm = (n < 10); end
        if (n == 10) begin cpu_req = 0; dma_req = 0; end
      end
    end
    cpu_req = 0; dma_req = 0; rearm = 0;
    checks++; if (n !== 10) begin errors++; $display("FAIL burst_ack_total got %0d exp 10", n); end
    checks++; if (seq !== 10'b1000010000) begin errors++; $display("FAIL burst_order got %b exp 1000010000", seq); end
    checks++; if (both !== 0) begin errors++; $display("FAIL burst_both_acks got %0d exp 0", both); end
  endtask

  // reset in the 2nd ACCESS cycle aborts the read with no ack
  task automatic test_reset_abort();
    int acks = 0, cs_n = 0, ack_e = 0;
    @(negedge clock);
    force_val = 8'hC3; cpu_we = 0; cpu_addr = 16'h0200; cpu_req = 1;
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    checks++;
    if (mem_cs !== 1'b0 || bus_owner !== 2'd0 || mem_oe !== 1'b0) begin
      errors++; $display("FAIL abort_drop cs %b owner %0d oe %b exp 0 0 0", mem_cs, bus_owner, mem_oe);
    end
    cpu_req = 0;
    @(posedge clock);
    @(negedge clock) reset = 1'b0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clock); #1;
      if (cpu_ack || dma_ack) acks++;
      if (mem_cs) cs_n++;
    end
    checks++; if (acks !== 0 || cs_n !== 0) begin errors++; $display("FAIL abort_quiet acks %0d cs %0d exp 0 0", acks, cs_n); end
    @(negedge clock);
    force_val = 8'h96; cpu_addr = 16'h0300; cpu_req = 1;
    for (int e = 1; e <= 7; e++) begin
      @(posedge clock); #1;
      if (cpu_ack) begin ack_e = e; cpu_req = 0; end
    end
    checks++; if (ack_e !== 4) begin errors++; $display("FAIL abort_restart_edge got %0d exp 4", ack_e); end
    checks++; if (cpu_rdata !== 8'h96) begin errors++; $display("FAIL abort_restart_data got %h exp 96", cpu_rdata); end
  endtask

  task automatic test_ws0();
    int cs_n = 0, ack_e = 0, cseen = 0;
    @(negedge clock);
    z_mem_rdata = 8'h5A; z_dma_we = 0; z_dma_addr = 16'h4000; z_dma_req = 1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clock); #1;
      if (z_mem_cs) cs_n++;
      if (z_cpu_ack) cseen++;
      if (z_dma_ack) begin ack_e = e; z_dma_req = 0; end
    end
    checks++; if (cs_n !== 1) begin errors++; $display("FAIL ws0_cs_cycles got %0d exp 1", cs_n); end
    checks++; if (ack_e !== 2) begin errors++; $display("FAIL ws0_ack_edge got %0d exp 2", ack_e); end
    checks++; if (z_dma_rdata !== 8'h5A) begin errors++; $display("FAIL ws0_data got %h exp 5a", z_dma_rdata); end
    checks++; if (cseen !== 0 || z_bus_owner !== 2'd0) begin errors++; $display("FAIL ws0_cpu_side cpu_acks %0d owner %0d exp 0 0", cseen, z_bus_owner); end
  endtask

  // random traffic vs. a model: each grant holds the bus W+3 cycles,
  // ack lands W+1 edges after grant, DMA wins ties until MAXB in a row
  task automatic test_random();
    bit m_act = 0, m_we = 0, cpu_cool = 0, dma_cool = 0;
    int m_t = 0, m_own = 0, m_burst = 0;
    logic [15:0] m_addr = 0;
    logic [7:0]  m_wd = 0, m_cpu_rd = 0, m_dma_rd = 0;
    logic        e_cs, e_cack, e_dack;
    logic [1:0]  e_own;
    cpu_req = 0; dma_req = 0; force_en = 0;
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      if (!cpu_req && !cpu_cool && $urandom_range(0, 2) == 0) begin
        cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom); cpu_req = 1;
      end
      if (!dma_req && !dma_cool && $urandom_range(0, 1) == 0) begin
        dma_we = 1'($urandom_range(0, 1)); dma_addr = 16'($urandom); dma_wdata = 8'($urandom); dma_req = 1;
      end
      cpu_cool = 0; dma_cool = 0;
      @(posedge clock);
      if (!m_act || m_t == W + 2) begin
        m_act = 0;
        if (cpu_req && (!dma_req || m_burst == MAXB)) begin
          m_act = 1; m_t = 0; m_own = 1; m_we = cpu_we; m_addr = cpu_addr; m_wd = cpu_wdata; m_burst = 0;
        end else if (dma_req) begin
          m_act = 1; m_t = 0; m_own = 2; m_we = dma_we; m_addr = dma_addr; m_wd = dma_wdata;
          m_burst = !cpu_req ? 0 : (m_burst < MAXB ? m_burst + 1 : m_burst);
        end
      end else m_t++;
      #1;
      e_cs   = m_act && m_t <= W;
      e_cack = m_act && m_t == W + 1 && m_own == 1;
      e_dack = m_act && m_t == W + 1 && m_own == 2;
      e_own  = (m_act && m_t <= W + 1) ? 2'(m_own) : 2'd0;
      if (e_cack && !m_we) m_cpu_rd = mem_fn(m_addr);
      if (e_dack && !m_we) m_dma_rd = mem_fn(m_addr);
      checks++; if (cpu_ack !== e_cack) begin errors++; $display("FAIL rnd_cpu_ack cyc %0d got %b exp %b", c, cpu_ack, e_cack); end
      checks++; if (dma_ack !== e_dack) begin errors++; $display("FAIL rnd_dma_ack cyc %0d got %b exp %b", c, dma_ack, e_dack); end
      checks++; if (mem_cs !== e_cs) begin errors++; $display("FAIL rnd_cs cyc %0d got %b exp %b", c, mem_cs, e_cs); end
      checks++; if (bus_owner !== e_own) begin errors++; $display("FAIL rnd_owner cyc %0d got %0d exp %0d", c, bus_owner, e_own); end
      checks++;
      if (mem_we !== (e_cs && m_we) || mem_oe !== (e_cs && m_we)) begin
        errors++; $display("FAIL rnd_we_oe cyc %0d got %b%b exp %b", c, mem_we, mem_oe, e_cs && m_we);
      end
      checks++; if (cpu_rdata !== m_cpu_rd) begin errors++; $display("FAIL rnd_cpu_rdata cyc %0d got %h exp %h", c, cpu_rdata, m_cpu_rd); end
      checks++; if (dma_rdata !== m_dma_rd) begin errors++; $display("FAIL rnd_dma_rdata cyc %0d got %h exp %h", c, dma_rdata, m_dma_rd); end
      if (e_cs) begin
        checks++; if (mem_addr !== m_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", c, mem_addr, m_addr); end
        if (m_we) begin
          checks++; if (mem_wdata !== m_wd) begin errors++; $display("FAIL rnd_wdata cyc %0d got %h exp %h", c, mem_wdata, m_wd); end
        end
      end
      if (e_cack) begin cpu_req = 0; cpu_cool = 1; end
      if (e_dack) begin dma_req = 0; dma_cool = 1; end
    end
    cpu_req = 0; dma_req = 0;
    repeat (8) @(posedge clock);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_simultaneous();
    repeat (3) @(posedge clock);
    test_dma_burst();
    repeat (8) @(posedge clock);
    test_reset_abort();
    test_ws0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the end of the run");
    $fatal(1, "watchdog");
  end

endmodule
